chan_scan_mux: RTL
==================

# chan_scan_mux

Parametrised registered N-to-1 lane multiplexer with a valid/ready output handshake. It has two modes: direct (lane chosen by `sel`) and auto-scan (on `start`, it emits every lane in order 0..CH-1, one per accepted transfer). It is the next-generation replacement for the fixed 16×4-bit selector. It sits between packed multi-lane data buses and single-lane consumers that can apply backpressure.

## Interface
- `CH`, 16: number of input lanes, ≥2, need not be a power of two.
- `W`, 4: lane width in bits, ≥1.
- `SELW`, `$clog2(CH)`: select/channel index width (derived, not overridden).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `A`  in  CH*W  packed lanes; lane k = `A[k*W +: W]`.
- `sel`  in  SELW  lane index for direct mode.
- `mode`  in  1  0 = direct, 1 = scan.
- `start`  in  1  single-cycle pulse; begins a scan when idle and `mode`=1.
- `out_ready`  in  1  consumer accepts `Y` this cycle.
- `Y`  out  W  registered selected lane.
- `y_ch`  out  SELW  lane index that `Y` came from.
- `out_valid`  out  1  `Y` / `y_ch` are valid.
- `out_last`  out  1  qualifies the final lane (CH-1) of a scan.
- `busy`  out  1  a scan is in progress.
- `sel_err`  out  1  registered; the last direct capture used `sel` ≥ CH.

## Operation
- Capture enable `cap` = !`out_valid` || `out_ready`. While `cap`=0, all outputs and the scan counter hold (stall).
- States: IDLE, SCAN.
- **IDLE, `mode`=0 (direct):** on every cycle with `cap`=1:
  - `Y` ← lane[`sel`], `y_ch` ← `sel`, `out_valid` ← 1, `out_last` ← 0.
  - `sel_err` ← (`sel` ≥ CH). When `sel` ≥ CH, `Y` ← 0.
- **IDLE, `mode`=1, no `start`:** on `cap`=1, `out_valid` ← 0. `Y` and `y_ch` hold their last values.
- **IDLE → SCAN:** when `mode`=1 && `start` && `cap`=1.
  - Counter `cnt` ← 1.
  - `Y` ← lane[0], `y_ch` ← 0, `out_valid` ← 1, `busy` ← 1, `sel_err` ← 0.
  - If `start` arrives with `cap`=0, it is ignored. The caller re-pulses.
- **SCAN:** on each cycle with `cap`=1:
  - `Y` ← lane[`cnt`], `y_ch` ← `cnt`, `cnt` ← `cnt`+1.
  - `out_last` ← (`cnt` == CH-1).
  - `A` is sampled live at each capture, not snapshotted at `start`.
- **SCAN → IDLE:** when the transfer with `out_last`=1 is accepted (`out_valid` && `out_ready` && `out_last`).
  - On that edge: `busy` ← 0, `out_last` ← 0, `cnt` ← 0.
  - `out_valid` then follows the IDLE rules on the same edge, using current `mode`/`sel`.
- **While in SCAN:** `mode`, `sel` and `start` are ignored. A `start` during SCAN does not restart the scan.
- **Counter:** width SELW. It never wraps past CH-1; the terminal compare is against CH-1, not 2^SELW-1.
- **Reset, including mid-scan:** on the next edge, state = IDLE, `cnt`=0, `Y`=0, `y_ch`=0, `out_valid`=0, `out_last`=0, `busy`=0, `sel_err`=0.

## Timing
- Latency: 1 cycle from `sel`/`A` sampled to `Y` valid (direct mode).
- Scan throughput: one lane per cycle with `out_ready` held high. A full scan takes CH cycles from the `start` edge to acceptance of the last lane.
- `start` to first valid `Y` (lane 0): 1 cycle.
- Stability rule: with `out_valid`=1 and `out_ready`=0, `Y`, `y_ch` and `out_last` are stable until accepted.
- No combinational path from any input to any output.

## Structure
- Shared package `chan_mux_pkg`:
  - state enum `{IDLE, SCAN}`;
  - mode constants `MODE_DIRECT`=1'b0, `MODE_SCAN`=1'b1.
- Sub-module `lane_sel` (combinational, parameters CH and W):
  - inputs `A`, `idx`; outputs `lane`, `oob`;
  - `lane` = 0 and `oob` = 1 when `idx` ≥ CH.
  - Used by both the direct path and the scan path through one index mux (`idx` = SCAN ? `cnt` : `sel`).
- Top-level module `chan_scan_mux` holds the FSM, the counter, the output registers and the handshake.

## Test plan
All scenarios use lane k = k (CH=16, W=4).
- **Direct sweep:** `mode`=0, `out_ready`=1, `sel`=0,1,2,3,4 on successive cycles → `Y`=0,1,2,3,4 each one cycle later, `y_ch` matching, `sel_err`=0, `out_valid`=1.
- **Full scan:** `mode`=1, `start` pulse, `out_ready`=1 → `Y` = 0..15 on 16 consecutive cycles, `out_last`=1 only with `Y`=15, `busy` drops after that acceptance.
- **Backpressure:** during scan, drop `out_ready` for 3 cycles while `Y`=5 → `Y`=5 and `y_ch`=5 held. Lane 6 appears one cycle after `out_ready` returns. No lane is skipped or duplicated.
- **Reset mid-scan:** assert `rst` while `Y`=9 → next edge: all outputs 0, `busy`=0. A new `start` then resumes from lane 0.
- **Non-power-of-two:** CH=10, W=8, scan → `y_ch` 0..9 with `out_last` on 9, no index 10–15. Direct `sel`=12 → `Y`=0, `sel_err`=1.
- **Ignored controls:** `start` and a `mode` toggle mid-scan → scan continues unaffected to lane 15.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// Shared types and constants for the channel scan multiplexer.
package chan_mux_pkg;

    // Controller states: IDLE serves direct selects, SCAN walks lanes 0..CH-1.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Values of the mode input.
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/chan_scan_mux_lane_sel.sv
// Combinational lane picker. An index beyond the last lane yields zero and flags oob.
module lane_sel #(
    parameter  int CH   = 16,
    parameter  int W    = 4,
    localparam int SELW = $clog2(CH)
) (
    input  logic [CH*W-1:0] A,
    input  logic [SELW-1:0] idx,
    output logic [W-1:0]    lane,
    output logic            oob
);

    // Compare against each real lane so non-power-of-two CH never reads past the bus.
    always_comb begin
        lane = '0;
        for (int k = 0; k < CH; k++) begin
            if (idx == SELW'(k)) begin
                lane = A[k*W +: W];
            end
        end
        oob = (32'(idx) >= CH);
    end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered CH-to-1 lane multiplexer with direct and auto-scan modes.
//
// Output handshake: a transfer happens on a rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0 the outputs Y, y_ch,
// out_last and the scan counter hold. A new value is captured only when
// cap = !out_valid || out_ready.
module chan_scan_mux
    import chan_mux_pkg::*;
#(
    parameter  int CH   = 16,
    parameter  int W    = 4,
    localparam int SELW = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH*W-1:0] A,
    input  logic [SELW-1:0] sel,
    input  logic            mode,
    input  logic            start,
    input  logic            out_ready,
    output logic [W-1:0]    Y,
    output logic [SELW-1:0] y_ch,
    output logic            out_valid,
    output logic            out_last,
    output logic            busy,
    output logic            sel_err
);

    localparam logic [SELW-1:0] LAST_IDX = SELW'(CH - 1);

    state_t          state, state_n;
    logic [SELW-1:0] cnt, cnt_n;
    logic [W-1:0]    y_n;
    logic [SELW-1:0] y_ch_n;
    logic            out_valid_n, out_last_n, sel_err_n;

    logic            cap;
    logic            scan_path;
    logic [SELW-1:0] idx;
    logic [W-1:0]    lane;
    logic            oob;

    assign cap = !out_valid || out_ready;

    // The counter feeds the picker while a scan still has lanes to emit, and also
    // in IDLE with scan mode so a start captures lane 0 (cnt is 0 in IDLE). When
    // the last lane is being accepted the IDLE rules apply, so sel drives instead.
    assign scan_path = (state == SCAN) ? !out_last : (mode == MODE_SCAN);
    assign idx       = scan_path ? cnt : sel;

    lane_sel #(
        .CH (CH),
        .W  (W)
    ) u_lane_sel (
        .A    (A),
        .idx  (idx),
        .lane (lane),
        .oob  (oob)
    );

    assign busy = (state == SCAN);

    // Next-state and next-output decode; everything holds unless cap is set.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        y_n         = Y;
        y_ch_n      = y_ch;
        out_valid_n = out_valid;
        out_last_n  = out_last;
        sel_err_n   = sel_err;
        if (cap) begin
            if (state == SCAN && !out_last) begin
                y_n        = lane;
                y_ch_n     = cnt;
                out_last_n = (cnt == LAST_IDX);
                // Saturate at the final lane; the finishing edge clears cnt.
                if (cnt != LAST_IDX) begin
                    cnt_n = cnt + 1'b1;
                end
            end else begin
                if (state == SCAN) begin
                    state_n    = IDLE;
                    cnt_n      = '0;
                    out_last_n = 1'b0;
                end
                if (mode == MODE_DIRECT) begin
                    y_n         = lane;
                    y_ch_n      = sel;
                    out_valid_n = 1'b1;
                    out_last_n  = 1'b0;
                    sel_err_n   = oob;
                end else if (start && state == IDLE) begin
                    state_n     = SCAN;
                    cnt_n       = SELW'(1);
                    y_n         = lane;
                    y_ch_n      = '0;
                    out_valid_n = 1'b1;
                    out_last_n  = 1'b0;
                    sel_err_n   = 1'b0;
                end else begin
                    out_valid_n = 1'b0;
                end
            end
        end
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            Y         <= '0;
            y_ch      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            Y         <= y_n;
            y_ch      <= y_ch_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            sel_err   <= sel_err_n;
        end
    end

endmodule
